// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID pipeline register with valid/ready handshake, one-entry skid, flush and stall counter
module if_id_skid #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int                CNT_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              stall_id,
  input  logic              flush,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              skid_full,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              accept;

  // Ready depends only on the skid flag, so no if_* to id_* combinational path exists.
  assign if_ready  = !skid_valid;
  assign accept    = if_valid & if_ready;
  assign skid_full = skid_valid;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_inst    <= NOP_INST;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
      stall_cnt  <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_inst    <= NOP_INST;
      skid_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (stall_id) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_pc    <= if_pc;
        skid_inst  <= if_inst;
      end
      if (stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
      // A held entry drains first; if_ready is low that cycle so nothing new is accepted.
      if (skid_valid) begin
        id_valid   <= 1'b1;
        id_pc      <= skid_pc;
        id_inst    <= skid_inst;
        skid_valid <= 1'b0;
      end else if (accept) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= '0;
        id_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - self-checking bench for if_id_skid with behavioural model and directed vectors
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          if_valid = 1'b0;
  logic [31:0]   if_pc = '0;
  logic [31:0]   if_inst = '0;
  logic          if_ready;
  logic          stall_id = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          skid_full;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_skid #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .stall_id(stall_id), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .skid_full(skid_full), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the skid is a FIFO of at most one entry, ID holds one slot.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
  entry_t      pend[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = NOP;
  int          m_cnt = 0;
  bit          model_ok = 1'b0;

  always @(posedge Clk) begin
    bit     acc;
    entry_t e;
    acc = if_valid && (pend.size() == 0);
    if (!Rst_n) begin
      m_valid = 0; m_pc = '0; m_inst = NOP; pend.delete(); m_cnt = 0; model_ok = 1;
    end else if (flush) begin
      m_valid = 0; m_pc = '0; m_inst = NOP; pend.delete(); m_cnt = 0;
    end else if (stall_id) begin
      if (acc) begin
        e.pc = if_pc; e.inst = if_inst; pend.push_back(e);
      end
      m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    end else begin
      m_cnt = 0;
      if (pend.size() != 0) begin
        e = pend.pop_front(); m_valid = 1; m_pc = e.pc; m_inst = e.inst;
      end else if (acc) begin
        m_valid = 1; m_pc = if_pc; m_inst = if_inst;
      end else begin
        m_valid = 0; m_pc = '0; m_inst = NOP;
      end
    end
  end

  always @(negedge Clk) begin
    if (model_ok) begin
      check("m_id_valid",  {31'b0, id_valid},  {31'b0, m_valid});
      check("m_id_pc",     id_pc,              m_pc);
      check("m_id_inst",   id_inst,            m_inst);
      check("m_skid_full", {31'b0, skid_full}, {31'b0, pend.size() != 0});
      check("m_if_ready",  {31'b0, if_ready},  {31'b0, pend.size() == 0});
      check("m_stall_cnt", {29'b0, stall_cnt}, m_cnt);
    end
  end

  task automatic cyc(input logic rn, input logic v, input logic [31:0] pc,
                     input logic st, input logic fl);
    Rst_n = rn; if_valid = v; if_pc = pc; if_inst = 32'hC0DE_0000 ^ pc;
    stall_id = st; flush = fl;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_id(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    check({name, "_pc"}, id_pc, pc);
    check({name, "_inst"}, id_inst, v ? (32'hC0DE_0000 ^ pc) : NOP);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    expect_id("reset", 0, 0);
    check("reset_skid", {31'b0, skid_full}, 0);
    check("reset_cnt", {29'b0, stall_cnt}, 0);
    check("reset_ready", {31'b0, if_ready}, 1);

    cyc(1, 1, 32'h100, 0, 0); expect_id("s100", 1, 32'h100);
    cyc(1, 1, 32'h104, 0, 0); expect_id("s104", 1, 32'h104);
    cyc(1, 1, 32'h108, 0, 0); expect_id("s108", 1, 32'h108);
    check("stream_ready", {31'b0, if_ready}, 1);

    cyc(1, 0, 32'h10c, 0, 0); expect_id("bubble", 0, 0);

    cyc(1, 1, 32'h100, 0, 0); expect_id("h100", 1, 32'h100);
    cyc(1, 1, 32'h104, 1, 0); expect_id("hold1", 1, 32'h100);
    check("hold1_ready", {31'b0, if_ready}, 0);
    check("hold1_skid", {31'b0, skid_full}, 1);
    check("hold1_cnt", {29'b0, stall_cnt}, 1);
    cyc(1, 1, 32'h108, 1, 0); expect_id("hold2", 1, 32'h100);
    check("hold2_cnt", {29'b0, stall_cnt}, 2);
    cyc(1, 1, 32'h108, 1, 0); expect_id("hold3", 1, 32'h100);
    check("hold3_cnt", {29'b0, stall_cnt}, 3);
    cyc(1, 1, 32'h108, 0, 0); expect_id("drain", 1, 32'h104);
    check("drain_cnt", {29'b0, stall_cnt}, 0);
    check("drain_ready", {31'b0, if_ready}, 1);
    cyc(1, 1, 32'h108, 0, 0); expect_id("after", 1, 32'h108);
    cyc(1, 0, 0, 0, 0); expect_id("bubble2", 0, 0);

    cyc(1, 1, 32'h200, 0, 0); expect_id("f200", 1, 32'h200);
    cyc(1, 1, 32'h204, 1, 0);
    check("fpre_skid", {31'b0, skid_full}, 1);
    cyc(1, 1, 32'h208, 1, 1); expect_id("flush", 0, 0);
    check("flush_skid", {31'b0, skid_full}, 0);
    check("flush_cnt", {29'b0, stall_cnt}, 0);
    check("flush_ready", {31'b0, if_ready}, 1);
    cyc(1, 1, 32'h208, 0, 0); expect_id("fpost", 1, 32'h208);

    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 1, 0);
      check("sat_cnt", {29'b0, stall_cnt}, (i + 1 < 7) ? i + 1 : 7);
    end
    expect_id("sat_hold", 1, 32'h208);
    cyc(1, 0, 0, 0, 0);
    check("sat_clear", {29'b0, stall_cnt}, 0);

    cyc(1, 1, 32'h300, 0, 0); expect_id("r300", 1, 32'h300);
    cyc(1, 1, 32'h304, 1, 0);
    check("rpre_skid", {31'b0, skid_full}, 1);
    cyc(0, 1, 32'h308, 1, 0); expect_id("rmid", 0, 0);
    check("rmid_skid", {31'b0, skid_full}, 0);
    check("rmid_cnt", {29'b0, stall_cnt}, 0);
    check("rmid_ready", {31'b0, if_ready}, 1);
    cyc(1, 1, 32'h308, 0, 0); expect_id("rpost", 1, 32'h308);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 4 * i;
      cyc(($urandom_range(0, 19) != 0), $urandom_range(0, 1), pc,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
